// File: rtl/cache_ctrl_if.sv
// CPU, tag-array and memory signals of the cache controller, bundled.
// slave = the controller, master = CPU, tag array and memory around it.
interface cache_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic        flush;
  logic        cpu_ready;
  logic        hit;
  logic [15:0] tag_add;
  logic [9:0]  tag_in;
  logic        tag_we;
  logic        data_we;
  logic        fill_we;
  logic [1:0]  fill_off;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic        mem_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, flush, tag_in, mem_ack,
    output cpu_ready, hit, tag_add, tag_we, data_we, fill_we, fill_off,
           mem_req, mem_we, mem_addr
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, flush, tag_in, mem_ack,
    input  cpu_ready, hit, tag_add, tag_we, data_we, fill_we, fill_off,
           mem_req, mem_we, mem_addr
  );
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped 16 x 4-byte cache controller: read-allocate, write-through no-allocate.
// Read hit completes 1 cycle after the request; refill/write hold mem_req until each mem_ack.
module cache_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  cache_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, UPDATE, WRITE} state_t;

  state_t      state, state_nxt;
  logic [15:0] valid, valid_nxt;
  logic [15:0] addr_q, addr_nxt;
  logic        we_q, we_nxt;
  logic [1:0]  beat, beat_nxt;

  logic [3:0]  idx;
  logic [9:0]  tag;
  logic        hit_raw;

  logic        cpu_ready_c, hit_c, tag_we_c, data_we_c, fill_we_c;
  logic        mem_req_c, mem_we_c;
  logic [1:0]  fill_off_c;
  logic [15:0] mem_addr_c;

  assign idx     = addr_q[5:2];
  assign tag     = addr_q[15:6];
  assign hit_raw = valid[idx] && (bus.tag_in == tag);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      valid  <= '0;
      addr_q <= '0;
      we_q   <= 1'b0;
      beat   <= 2'd0;
    end else begin
      state  <= state_nxt;
      valid  <= valid_nxt;
      addr_q <= addr_nxt;
      we_q   <= we_nxt;
      beat   <= beat_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    valid_nxt   = valid;
    addr_nxt    = addr_q;
    we_nxt      = we_q;
    beat_nxt    = beat;
    cpu_ready_c = 1'b0;
    hit_c       = 1'b0;
    tag_we_c    = 1'b0;
    data_we_c   = 1'b0;
    fill_we_c   = 1'b0;
    fill_off_c  = 2'd0;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;

    case (state)
      IDLE: begin
        // flush wins over a simultaneous request
        if (bus.flush) begin
          valid_nxt = '0;
        end else if (bus.cpu_req) begin
          addr_nxt  = bus.cpu_addr;
          we_nxt    = bus.cpu_we;
          state_nxt = LOOKUP;
        end
      end

      LOOKUP: begin
        hit_c = hit_raw;
        if (we_q) begin
          data_we_c = hit_raw;
          state_nxt = WRITE;
        end else if (hit_raw) begin
          cpu_ready_c = 1'b1;
          state_nxt   = IDLE;
        end else begin
          beat_nxt  = 2'd0;
          state_nxt = REFILL;
        end
      end

      REFILL: begin
        mem_req_c  = 1'b1;
        mem_addr_c = {addr_q[15:2], beat};
        fill_off_c = beat;
        if (bus.mem_ack) begin
          fill_we_c = 1'b1;
          beat_nxt  = beat + 2'd1;
          if (beat == 2'd3) begin
            state_nxt = UPDATE;
          end
        end
      end

      UPDATE: begin
        // tag and valid commit together; the retry lookup then hits
        tag_we_c       = 1'b1;
        valid_nxt[idx] = 1'b1;
        state_nxt      = LOOKUP;
      end

      WRITE: begin
        mem_req_c  = 1'b1;
        mem_we_c   = 1'b1;
        mem_addr_c = addr_q;
        if (bus.mem_ack) begin
          cpu_ready_c = 1'b1;
          state_nxt   = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held, before the reset edge lands.
  assign bus.cpu_ready = rst_n & cpu_ready_c;
  assign bus.hit       = rst_n & hit_c;
  assign bus.tag_we    = rst_n & tag_we_c;
  assign bus.data_we   = rst_n & data_we_c;
  assign bus.fill_we   = rst_n & fill_we_c;
  assign bus.mem_req   = rst_n & mem_req_c;
  assign bus.mem_we    = rst_n & mem_we_c;
  assign bus.fill_off  = rst_n ? fill_off_c : 2'd0;
  assign bus.mem_addr  = rst_n ? mem_addr_c : 16'd0;
  assign bus.tag_add   = rst_n ? addr_q     : 16'd0;

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: cache-content model feeds expectation queues, monitor pops.
module tb_cache_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_ctrl_if bus ();
  cache_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  // external tag array
  logic [9:0] tag_mem [16];
  assign bus.tag_in = tag_mem[bus.tag_add[5:2]];
  always @(posedge clk) if (bus.tag_we) tag_mem[bus.tag_add[5:2]] <= bus.tag_add[15:6];

  int n_chk = 0;
  int n_fail = 0;
  int fill_cnt = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(string msg);
    n_chk++;
    n_fail++;
    $display("FAIL %s", msg);
  endtask

  // reference model: cache contents and expected events
  typedef struct packed {logic [15:0] addr; logic we;} xfer_t;
  bit         m_valid [16];
  logic [9:0] m_tag   [16];
  xfer_t       exp_mem[$];
  xfer_t       exp_done[$];
  logic [15:0] exp_tag[$];
  logic [15:0] exp_dwe[$];

  task automatic model_clear();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endtask

  // memory responder
  int fixed_wait = 0;
  bit spur_en = 1'b0;
  bit ack_force = 1'b0;
  int wait_left = 0;

  function automatic int pick_wait();
    return (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
  endfunction

  always @(posedge clk) begin
    #1;
    if (ack_force) begin
      bus.mem_ack = 1'b1;
    end else if (bus.mem_req) begin
      if (wait_left == 0) begin
        bus.mem_ack = 1'b1;
        wait_left = pick_wait();
      end else begin
        bus.mem_ack = 1'b0;
        wait_left--;
      end
    end else begin
      bus.mem_ack = spur_en ? 1'($urandom % 2) : 1'b0;
      wait_left = pick_wait();
    end
  end

  // monitor
  always @(negedge clk) begin
    xfer_t e;
    int n;
    if (rst_n === 1'b1) begin
      n = int'(bus.tag_we) + int'(bus.data_we) + int'(bus.fill_we) + int'(bus.cpu_ready);
      if (n > 0) check("strobes_exclusive", (n > 1) ? 1 : 0, 0);
      if (bus.fill_we) fill_cnt++;

      if (bus.mem_req && bus.mem_ack) begin
        if (exp_mem.size() == 0) begin
          fail($sformatf("mem_unexpected: got transfer at 0x%0h we=%0b, required none",
                         bus.mem_addr, bus.mem_we));
        end else begin
          e = exp_mem.pop_front();
          check("mem_addr", bus.mem_addr, e.addr);
          check("mem_we", bus.mem_we, e.we);
          check("fill_we_on_ack", bus.fill_we, !e.we);
          if (!e.we) check("fill_off", bus.fill_off, e.addr[1:0]);
        end
      end else if (bus.fill_we) begin
        fail($sformatf("fill_unexpected: got fill_we=1 off=%0d, required 0", bus.fill_off));
      end

      if (bus.tag_we) begin
        if (exp_tag.size() == 0)
          fail($sformatf("tag_we_unexpected: got tag_we at 0x%0h, required none", bus.tag_add));
        else
          check("tag_add_on_tag_we", bus.tag_add, exp_tag.pop_front());
      end

      if (bus.data_we) begin
        if (exp_dwe.size() == 0)
          fail($sformatf("data_we_unexpected: got data_we at 0x%0h, required none", bus.tag_add));
        else
          check("tag_add_on_data_we", bus.tag_add, exp_dwe.pop_front());
      end

      if (bus.cpu_ready) begin
        if (exp_done.size() == 0) begin
          fail($sformatf("ready_unexpected: got cpu_ready at 0x%0h, required none", bus.tag_add));
        end else begin
          e = exp_done.pop_front();
          check("done_addr", bus.tag_add, e.addr);
          check("done_kind", bus.mem_we, e.we);
          if (!e.we) check("read_done_hit", bus.hit, 1);
        end
      end
    end
  end

  task automatic check_zero(string tagname);
    check({tagname, "_cpu_ready"}, bus.cpu_ready, 0);
    check({tagname, "_strobes"}, {bus.tag_we, bus.data_we, bus.fill_we}, 0);
    check({tagname, "_mem"}, {bus.mem_req, bus.mem_we}, 0);
    check({tagname, "_fill_off"}, bus.fill_off, 0);
    check({tagname, "_mem_addr"}, bus.mem_addr, 0);
    check({tagname, "_tag_add"}, bus.tag_add, 0);
  endtask

  // call just after a posedge; reset edge is the next posedge
  task automatic do_reset();
    rst_n = 1'b0;
    bus.cpu_req = 1'b0;
    bus.flush = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_zero("in_reset");
    end
    exp_mem.delete(); exp_done.delete(); exp_tag.delete(); exp_dwe.delete();
    model_clear();
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("after_reset");
    ack_force = 1'b0;
  endtask

  task automatic access(input logic [15:0] a, input bit w, input bit noise,
                        output bit h, output int lat);
    logic [3:0] idx;
    logic [9:0] tg;
    bit done;
    idx = a[5:2];
    tg  = a[15:6];
    h = m_valid[idx] && (m_tag[idx] == tg);
    if (!w) begin
      if (!h) begin
        for (int b = 0; b < 4; b++) exp_mem.push_back(xfer_t'{addr: {a[15:2], 2'(b)}, we: 1'b0});
        exp_tag.push_back(a);
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
      end
    end else begin
      if (h) exp_dwe.push_back(a);
      exp_mem.push_back(xfer_t'{addr: a, we: 1'b1});
    end
    exp_done.push_back(xfer_t'{addr: a, we: w});

    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_addr = a; bus.cpu_we = w; bus.flush = 1'b0;
    lat = 0;
    done = 1'b0;
    while (!done && lat < 300) begin
      @(negedge clk);
      lat++;
      if (bus.cpu_ready) done = 1'b1;
      if (done || !noise) begin
        bus.cpu_req = 1'b0; bus.flush = 1'b0;
      end else begin
        bus.cpu_req  = 1'($urandom % 2);
        bus.cpu_addr = 16'($urandom);
        bus.cpu_we   = 1'($urandom % 2);
        bus.flush    = ($urandom % 4 == 0);
      end
    end
    if (!done) begin
      fail($sformatf("timeout: no cpu_ready for 0x%0h within %0d cycles, required one", a, lat));
      @(posedge clk); #2;
      do_reset();
    end
  endtask

  task automatic do_flush(input bit with_req);
    @(negedge clk);
    bus.flush = 1'b1; bus.cpu_req = with_req; bus.cpu_addr = 16'h1234; bus.cpu_we = 1'b0;
    @(negedge clk);
    bus.flush = 1'b0; bus.cpu_req = 1'b0;
    model_clear();
    check("flush_no_start", {bus.mem_req, bus.cpu_ready}, 0);
  endtask

  initial begin
    bit h;
    int lat;
    int f0;
    int r;
    rst_n = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.flush = 1'b0;
    bus.mem_ack = 1'b0;
    model_clear();
    do_reset();

    // first read misses and refills, repeat hits
    fixed_wait = 0;
    access(16'h1234, 1'b0, 1'b0, h, lat);
    check("miss_latency_1234", lat, 7);
    access(16'h1235, 1'b0, 1'b0, h, lat);
    check("hit_latency_1235", lat, 1);

    // same index, new tag evicts the old one
    access(16'h5234, 1'b0, 1'b0, h, lat);
    check("miss_latency_5234", lat, 7);
    access(16'h1234, 1'b0, 1'b0, h, lat);
    check("remiss_latency_1234", lat, 7);

    // writes: hit on a valid line, then a line that is absent (not allocated)
    fixed_wait = 3;
    access(16'h1236, 1'b1, 1'b0, h, lat);
    check("write_hit_latency", lat, 5);
    access(16'h0040, 1'b1, 1'b0, h, lat);
    check("write_miss_latency", lat, 5);
    fixed_wait = 0;
    access(16'h0040, 1'b0, 1'b0, h, lat);
    check("no_allocate_read_miss", lat, 7);

    // flush beats a simultaneous request
    do_flush(1'b1);
    @(negedge clk);
    check("flush_still_idle", {bus.mem_req, bus.cpu_ready}, 0);
    access(16'h1234, 1'b0, 1'b0, h, lat);
    check("post_flush_miss", lat, 7);

    // reset after the second refill beat
    exp_mem.push_back(xfer_t'{addr: 16'h2234, we: 1'b0});
    exp_mem.push_back(xfer_t'{addr: 16'h2235, we: 1'b0});
    f0 = fill_cnt;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'h2234; bus.cpu_we = 1'b0;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    for (int i = 0; i < 50 && fill_cnt < f0 + 2; i++) @(posedge clk);
    check("beats_before_reset", fill_cnt - f0, 2);
    #2;
    ack_force = 1'b1;
    do_reset();
    access(16'h1234, 1'b0, 1'b0, h, lat);
    check("post_reset_miss", lat, 7);

    // randomized traffic with input noise, spurious acks and random waits
    fixed_wait = -1;
    spur_en = 1'b1;
    for (int k = 0; k < 150; k++) begin
      logic [15:0] a;
      r = int'($urandom % 20);
      if (r == 0) begin
        do_flush(1'($urandom % 2));
      end else begin
        a = {10'($urandom_range(0, 2) * 10'h155), 2'b00, 2'($urandom_range(0, 3)), 2'($urandom)};
        access(a, ($urandom % 3 == 0), 1'b1, h, lat);
        if (h && !bus.mem_we && lat <= 1) check("rand_read_hit_latency", lat, 1);
        else if (h && lat > 1 && exp_done.size() == 0 && !bus.mem_we && r > 6) check("rand_read_hit_latency", lat, 1);
      end
    end
    spur_en = 1'b0;
    repeat (4) @(negedge clk);
    check("queues_drained", exp_mem.size() + exp_done.size() + exp_tag.size() + exp_dwe.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
